// File: rtl/memory_rndgen_pipe.sv
// Instruction-fetch memory model: tagged direct-mapped store, LFSR fill on miss, pipelined response.
// Define RNDMEM_WRITE_PORT_EN to add the preload write port (write wins over a same-cycle read).
module memory_rndgen_pipe #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 12,
    parameter int          DEPTH      = 64,
    parameter int          LATENCY    = 1,
    parameter int          MEM_THRESH = 26,
    parameter logic [31:0] SEED       = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
`ifdef RNDMEM_WRITE_PORT_EN
    input  logic                  ifu_wr_req,
    input  logic [ADDR_WIDTH-1:0] ifu_wr_addr,
    input  logic [DATA_WIDTH-1:0] ifu_wr_data,
`endif
    output logic [15:0]           gen_count
);

    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [8:0]  THRESH   = 9'(MEM_THRESH);
    localparam logic [31:0] TAPS     = 32'h8020_0003;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DEPTH-1:0]      st_vld;
    logic [ADDR_WIDTH-1:0] st_tag  [DEPTH];
    logic [DATA_WIDTH-1:0] st_word [DEPTH];
    logic [31:0]           lfsr;

    logic [IDX_W-1:0]      rd_idx;
    logic                  hit, bypass, conflict, miss, gen, fill;
    logic [DATA_WIDTH-1:0] byp_data, gen_word, rd_word;
    logic [2:0]            op;
    logic [31:0]           lfsr_nxt;

    assign rd_idx = ifu_rd_addr[IDX_W-1:0];
    assign hit    = st_vld[rd_idx] && (st_tag[rd_idx] == ifu_rd_addr);

`ifdef RNDMEM_WRITE_PORT_EN
    logic [IDX_W-1:0] wr_idx;
    assign wr_idx   = ifu_wr_addr[IDX_W-1:0];
    assign bypass   = ifu_wr_req && (ifu_wr_addr == ifu_rd_addr);
    // A write to the read's entry under a different tag forces a miss whose word is not kept.
    assign conflict = ifu_wr_req && (wr_idx == rd_idx) && !bypass;
    assign byp_data = ifu_wr_data;
`else
    assign bypass   = 1'b0;
    assign conflict = 1'b0;
    assign byp_data = '0;
`endif

    always_comb begin
        op = 3'o7;
        if ({1'b0, lfsr[31:24]} < THRESH)
            op = (lfsr[2:0] >= 3'd6) ? (lfsr[2:0] - 3'd6) : lfsr[2:0];
        gen_word = {op, lfsr[DATA_WIDTH-4:0]};
        lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'd0);
    end

    assign miss    = !bypass && (!hit || conflict);
    assign gen     = ifu_rd_req && miss;
    assign fill    = gen && !conflict;
    assign rd_word = bypass ? byp_data : (miss ? gen_word : st_word[rd_idx]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_vld    <= '0;
            lfsr      <= SEED_EFF;
            gen_count <= '0;
        end else begin
            if (gen) begin
                lfsr      <= lfsr_nxt;
                gen_count <= sat_inc16(gen_count);
            end
            if (fill)
                st_vld[rd_idx] <= 1'b1;
`ifdef RNDMEM_WRITE_PORT_EN
            if (ifu_wr_req)
                st_vld[wr_idx] <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            st_tag[rd_idx]  <= ifu_rd_addr;
            st_word[rd_idx] <= gen_word;
        end
`ifdef RNDMEM_WRITE_PORT_EN
        if (ifu_wr_req) begin
            st_tag[wr_idx]  <= ifu_wr_addr;
            st_word[wr_idx] <= ifu_wr_data;
        end
`endif
    end

    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] stg_ld;

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        logic [DATA_WIDTH-1:0] data_p;
        logic [DATA_WIDTH-1:0] din;
        if (g == 0) begin : g_head
            // stage 0: lookup result captured at the accepting edge
            assign stg_ld[g] = ifu_rd_req;
            assign din       = rd_word;
        end else begin : g_tail
            // stage g: shifted from stage g-1
            assign stg_ld[g] = vld_p[g-1];
            assign din       = g_stage[g-1].data_p;
        end
        if (g == LATENCY - 1) begin : g_out
            always_ff @(posedge clk) begin
                if (!rst_n)
                    data_p <= '0;
                else if (stg_ld[g])
                    data_p <= din;
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (stg_ld[g])
                    data_p <= din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            vld_p <= '0;
        else
            vld_p <= stg_ld;
    end

    assign ifu_rd_valid = vld_p[LATENCY-1];
    assign ifu_rd_data  = g_stage[LATENCY-1].data_p;

endmodule

// File: tb/tb_memory_rndgen_pipe.sv
// Bench for memory_rndgen_pipe: four instances (latency 3/4, thresholds 0/255) against an array/LFSR model.
// The preload/bypass scenario runs only when RNDMEM_WRITE_PORT_EN is defined.
module tb_memory_rndgen_pipe;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [3:0]          req;
    logic [3:0][11:0]    addr;
    logic [3:0]          vld;
    logic [3:0][11:0]    dat;
    logic [3:0][15:0]    gc;
    logic                v0, v1, v2, v3;
    logic [11:0]         d0, d1, d2, d3;
    logic [15:0]         g0, g1, g2, g3;
`ifdef RNDMEM_WRITE_PORT_EN
    logic                wr_req;
    logic [11:0]         wr_addr, wr_data;
`endif

    assign vld = {v3, v2, v1, v0};
    assign dat = {d3, d2, d1, d0};
    assign gc  = {g3, g2, g1, g0};

    memory_rndgen_pipe #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .ifu_rd_req(req[0]), .ifu_rd_addr(addr[0]),
        .ifu_rd_data(d0), .ifu_rd_valid(v0),
`ifdef RNDMEM_WRITE_PORT_EN
        .ifu_wr_req(wr_req), .ifu_wr_addr(wr_addr), .ifu_wr_data(wr_data),
`endif
        .gen_count(g0));

    memory_rndgen_pipe #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .ifu_rd_req(req[1]), .ifu_rd_addr(addr[1]),
        .ifu_rd_data(d1), .ifu_rd_valid(v1),
`ifdef RNDMEM_WRITE_PORT_EN
        .ifu_wr_req(1'b0), .ifu_wr_addr(12'd0), .ifu_wr_data(12'd0),
`endif
        .gen_count(g1));

    memory_rndgen_pipe #(.LATENCY(1), .MEM_THRESH(0)) u_t0 (
        .clk(clk), .rst_n(rst_n), .ifu_rd_req(req[2]), .ifu_rd_addr(addr[2]),
        .ifu_rd_data(d2), .ifu_rd_valid(v2),
`ifdef RNDMEM_WRITE_PORT_EN
        .ifu_wr_req(1'b0), .ifu_wr_addr(12'd0), .ifu_wr_data(12'd0),
`endif
        .gen_count(g2));

    memory_rndgen_pipe #(.LATENCY(1), .MEM_THRESH(255)) u_t255 (
        .clk(clk), .rst_n(rst_n), .ifu_rd_req(req[3]), .ifu_rd_addr(addr[3]),
        .ifu_rd_data(d3), .ifu_rd_valid(v3),
`ifdef RNDMEM_WRITE_PORT_EN
        .ifu_wr_req(1'b0), .ifu_wr_addr(12'd0), .ifu_wr_data(12'd0),
`endif
        .gen_count(g3));

    int LAT [4] = '{3, 4, 1, 1};
    int THR [4] = '{26, 26, 0, 255};

    // Reference model: one associative view of each store plus its generator state.
    bit          m_v [4][64];
    logic [11:0] m_t [4][64];
    logic [11:0] m_w [4][64];
    logic [31:0] m_l [4];
    int          m_g [4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int id);
        for (int j = 0; j < 64; j++) m_v[id][j] = 1'b0;
        m_l[id] = SEED;
        m_g[id] = 0;
    endtask

    function automatic logic [11:0] model_word(input logic [31:0] l, input int thr);
        int op;
        if (int'(l[31:24]) < thr) op = int'(l[2:0]) % 6;
        else                      op = 7;
        return {3'(op), l[8:0]};
    endfunction

    task automatic model_read(input int id, input logic [11:0] a, output logic [11:0] w);
        int ix;
        ix = int'(a) % 64;
        if (m_v[id][ix] && m_t[id][ix] == a) begin
            w = m_w[id][ix];
        end else begin
            w = model_word(m_l[id], THR[id]);
            m_v[id][ix] = 1'b1;
            m_t[id][ix] = a;
            m_w[id][ix] = w;
            m_l[id] = (m_l[id] >> 1) ^ (m_l[id][0] ? 32'h8020_0003 : 32'd0);
            m_g[id]++;
        end
    endtask

    // Called #1 after the accepting edge; follows the response to its strobe.
    task automatic wait_strobe(input int id, output logic [11:0] w);
        int cyc;
        cyc = 1;
        while (!vld[id] && cyc < LAT[id] + 4) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("strobe", 64'(vld[id]), 64'd1);
        chk("latency", 64'(cyc), 64'(LAT[id]));
        w = dat[id];
    endtask

    task automatic rd(input int id, input logic [11:0] a, output logic [11:0] w);
        req[id]  = 1'b1;
        addr[id] = a;
        @(posedge clk); #1;
        req[id] = 1'b0;
        wait_strobe(id, w);
    endtask

    task automatic rd_chk(input int id, input logic [11:0] a, input string tag, output logic [11:0] w);
        logic [11:0] e;
        rd(id, a, w);
        model_read(id, a, e);
        chk(tag, 64'(w), 64'(e));
        chk({tag, "_gen_count"}, 64'(gc[id]), 64'(m_g[id]));
    endtask

    initial begin
        logic [11:0] s1, w, w3, e1, e2, a;
        logic [31:0] pre;
        int base;

        rst_n = 1'b0;
        req   = '0;
        addr  = '0;
`ifdef RNDMEM_WRITE_PORT_EN
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
`endif
        for (int id = 0; id < 4; id++) model_reset(id);

        repeat (3) @(posedge clk);
        #1;
        for (int id = 0; id < 4; id++) begin
            chk("reset_valid", 64'(vld[id]), 64'd0);
            chk("reset_data", 64'(dat[id]), 64'd0);
            chk("reset_gen_count", 64'(gc[id]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First miss, hit, eviction on the latency-3 instance.
        rd_chk(0, 12'o0100, "first_miss", s1);
        chk("first_miss_seed_word", 64'(s1), 64'(model_word(SEED, 26)));
        chk("first_miss_count", 64'(gc[0]), 64'd1);
        rd_chk(0, 12'o0100, "hit", w);
        chk("hit_same_word", 64'(w), 64'(s1));
        chk("hit_count", 64'(gc[0]), 64'd1);
        rd_chk(0, 12'o0200, "evict_other", w);
        rd_chk(0, 12'o0100, "evict_refill", w3);
        chk("evict_count", 64'(gc[0]), 64'd3);
        chk("evict_word_differs", 64'(w3 != s1), 64'd1);

        for (int i = 0; i < 40; i++) begin
            a = 12'(($urandom_range(0, 3) << 6) | $urandom_range(0, 3));
            rd_chk(0, a, "mixed_read", w);
        end

`ifdef RNDMEM_WRITE_PORT_EN
        begin
            int gb;
            gb = m_g[0];
            wr_req = 1'b1; wr_addr = 12'o0020; wr_data = 12'o7402;
            req[0] = 1'b1; addr[0] = 12'o0020;
            @(posedge clk); #1;
            wr_req = 1'b0; req[0] = 1'b0;
            m_v[0][16] = 1'b1; m_t[0][16] = 12'o0020; m_w[0][16] = 12'o7402;
            wait_strobe(0, w);
            chk("bypass_word", 64'(w), 64'o7402);
            chk("bypass_count", 64'(gc[0]), 64'(gb));
            rd_chk(0, 12'o0020, "preload_reread", w);
            chk("preload_reread_word", 64'(w), 64'o7402);
        end
`endif

        // Back-to-back reads of one missing address: only the first generates.
        req[2] = 1'b1; addr[2] = 12'o7700;
        @(posedge clk); #1;
        model_read(2, 12'o7700, e1);
        chk("b2b_first_valid", 64'(vld[2]), 64'd1);
        chk("b2b_first_word", 64'(dat[2]), 64'(e1));
        @(posedge clk); #1;
        req[2] = 1'b0;
        model_read(2, 12'o7700, e2);
        chk("b2b_second_valid", 64'(vld[2]), 64'd1);
        chk("b2b_second_word", 64'(dat[2]), 64'(e2));
        chk("b2b_count", 64'(gc[2]), 64'd1);

        // Opcode bias at both threshold extremes over unique addresses.
        base = int'($urandom_range(0, 4095));
        for (int i = 0; i < 200; i++) begin
            a = 12'((i * 17 + base) % 4096);
            rd_chk(2, a, "thresh0_word", w);
            chk("thresh0_opcode", 64'(w[11:9]), 64'd7);
        end
        base = int'($urandom_range(0, 4095));
        for (int i = 0; i < 200; i++) begin
            a = 12'((i * 17 + base) % 4096);
            pre = m_l[3];
            rd_chk(3, a, "thresh255_word", w);
            if (pre[31:24] != 8'hFF)
                chk("thresh255_opcode_range", 64'(w[11:9] <= 3'd5), 64'd1);
        end
        chk("thresh255_count", 64'(gc[3]), 64'd200);

        // Reset with three requests in flight on the latency-4 instance.
        req[1] = 1'b1; addr[1] = 12'o0100;
        @(posedge clk); #1;
        addr[1] = 12'o0300;
        @(posedge clk); #1;
        addr[1] = 12'o0500;
        @(posedge clk); #1;
        req[1] = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int id = 0; id < 4; id++) model_reset(id);
        for (int k = 0; k < 8; k++) begin
            chk("flush_no_strobe", 64'(vld[1]), 64'd0);
            @(posedge clk); #1;
        end
        chk("flush_gen_count", 64'(gc[1]), 64'd0);
        rd_chk(1, 12'o0100, "after_reset_word", w);
        chk("after_reset_matches_first", 64'(w), 64'(s1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
